// File: rtl/adc_ctrl.sv
// ADC acquisition sequencer: settle for a programmed time, request a conversion, capture the result.
// Optional macro ADC_AVG_EN: four settle+convert rounds per start, result is the truncated mean.
module adc_ctrl #(
  parameter int unsigned CLK_MHZ     = 100,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic [14:0] time_us,
  output logic        adc_conv,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic        busy,
  output logic [11:0] result,
  output logic        result_vld,
  output logic        err_timeout
);

  // state  | meaning
  // IDLE   | waiting for start; result/err_timeout hold last outcome
  // SETTLE | acquisition delay, time_us * CLK_MHZ cycles
  // CONV   | adc_conv asserted, waiting for adc_done or timeout

  typedef enum logic [1:0] {IDLE, SETTLE, CONV} state_t;

  localparam logic [7:0]  PRE_LOAD = 8'(CLK_MHZ - 1);
  localparam logic [15:0] TO_LOAD  = 16'(TIMEOUT_CYC - 1);

  state_t      r_state;
  logic [7:0]  r_pre;
  logic [14:0] r_us;
  logic [15:0] r_to;
  logic        r_busy;
  logic        r_conv;
  logic [11:0] r_result;
  logic        r_vld;
  logic        r_err;

`ifdef ADC_AVG_EN
  logic [14:0] r_time;
  logic [1:0]  r_round;
  logic [13:0] r_acc;
  logic [13:0] w_sum;

  assign w_sum = r_acc + 14'(adc_data);
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state  <= IDLE;
      r_pre    <= '0;
      r_us     <= '0;
      r_to     <= '0;
      r_busy   <= 1'b0;
      r_conv   <= 1'b0;
      r_result <= '0;
      r_vld    <= 1'b0;
      r_err    <= 1'b0;
`ifdef ADC_AVG_EN
      r_time   <= '0;
      r_round  <= '0;
      r_acc    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            r_vld  <= 1'b0;
            r_err  <= 1'b0;
            r_pre  <= PRE_LOAD;
            r_us   <= time_us - 15'd1;
            r_to   <= TO_LOAD;
`ifdef ADC_AVG_EN
            r_time  <= time_us;
            r_round <= '0;
            r_acc   <= '0;
`endif
            if (time_us == 15'd0) begin
              r_state <= CONV;
              r_conv  <= 1'b1;
            end else begin
              r_state <= SETTLE;
            end
          end
        end

        SETTLE: begin
          if (r_pre == 8'd0) begin
            if (r_us == 15'd0) begin
              r_state <= CONV;
              r_conv  <= 1'b1;
              r_to    <= TO_LOAD;
            end else begin
              r_us  <= r_us - 15'd1;
              r_pre <= PRE_LOAD;
            end
          end else begin
            r_pre <= r_pre - 8'd1;
          end
        end

        CONV: begin
          // done wins over timeout on the final cycle
          if (adc_done) begin
`ifdef ADC_AVG_EN
            if (r_round == 2'd3) begin
              r_state  <= IDLE;
              r_conv   <= 1'b0;
              r_busy   <= 1'b0;
              r_vld    <= 1'b1;
              r_result <= w_sum[13:2];
              r_acc    <= w_sum;
            end else begin
              r_round <= r_round + 2'd1;
              r_acc   <= w_sum;
              r_pre   <= PRE_LOAD;
              r_us    <= r_time - 15'd1;
              r_to    <= TO_LOAD;
              if (r_time != 15'd0) begin
                r_state <= SETTLE;
                r_conv  <= 1'b0;
              end
            end
`else
            r_state  <= IDLE;
            r_conv   <= 1'b0;
            r_busy   <= 1'b0;
            r_vld    <= 1'b1;
            r_result <= adc_data;
`endif
          end else if (r_to == 16'd0) begin
            r_state <= IDLE;
            r_conv  <= 1'b0;
            r_busy  <= 1'b0;
            r_vld   <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_to <= r_to - 16'd1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_conv  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign adc_conv    = r_conv;
  assign busy        = r_busy;
  assign result      = r_result;
  assign result_vld  = r_vld;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_adc_ctrl.sv
// Scoreboard bench for adc_ctrl: stimulus queues expected busy/conv/completion events, a negedge monitor checks them.
module tb_adc_ctrl;

  localparam int C  = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        start = 1'b0;
  logic [14:0] time_us = '0;
  logic        adc_conv;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic        busy;
  logic [11:0] result;
  logic        result_vld;
  logic        err_timeout;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [11:0] res;
    logic        vld;
    logic        err;
  } done_t;

  done_t q_done[$];
  int    q_busy[$];
  int    q_conv[$];

  adc_ctrl #(.CLK_MHZ(C), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .arst(arst), .start(start), .time_us(time_us),
    .adc_conv(adc_conv), .adc_done(adc_done), .adc_data(adc_data),
    .busy(busy), .result(result), .result_vld(result_vld), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: compare every busy/adc_conv edge against the queued expectations
  logic  prev_busy = 1'b0;
  logic  prev_conv = 1'b0;
  done_t e;
  always @(negedge clk) begin
    if (busy === 1'b1 && prev_busy !== 1'b1) begin
      if (q_busy.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_busy_rise: got rise at cycle %0d, expected none", cyc);
      end else begin
        chk("busy_rise_cycle", cyc, q_busy.pop_front());
        chk("vld_cleared_on_start", result_vld, 0);
        chk("err_cleared_on_start", err_timeout, 0);
      end
    end
    if (busy !== 1'b1 && prev_busy === 1'b1) begin
      if (q_done.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_completion: got busy fall at cycle %0d, expected none", cyc);
      end else begin
        e = q_done.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("result", result, e.res);
        chk("result_vld", result_vld, e.vld);
        chk("err_timeout", err_timeout, e.err);
        chk("conv_low_at_done", adc_conv, 0);
      end
    end
    if (adc_conv === 1'b1 && prev_conv !== 1'b1) begin
      if (q_conv.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_conv_rise: got rise at cycle %0d, expected none", cyc);
      end else begin
        chk("conv_rise_cycle", cyc, q_conv.pop_front());
      end
    end
    prev_busy = busy;
    prev_conv = adc_conv;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_done(input logic [11:0] d);
    adc_done = 1'b1;
    adc_data = d;
    tick();
    adc_done = 1'b0;
    adc_data = '0;
  endtask

  task automatic issue_start(input logic [14:0] t, output int n);
    n = cyc;
    time_us = t;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int n;
    #1 arst = 1'b1;
    tick(); tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_conv", adc_conv, 0);
    chk("rst_result", result, 0);
    chk("rst_vld", result_vld, 0);
    chk("rst_err", err_timeout, 0);
    arst = 1'b0;
    tick();

`ifdef ADC_AVG_EN
    // four rounds, time_us=1: each round is 4 settle cycles + done on the 2nd conv cycle
    issue_start(15'd1, n);
    q_busy.push_back(n + 1);
    for (int r = 0; r < 4; r++) q_conv.push_back(n + 5 + 6 * r);
    q_done.push_back('{n + 25, 12'h102, 1'b1, 1'b0});
    wait_until(n + 6);  pulse_done(12'h100);
    wait_until(n + 12); pulse_done(12'h101);
    wait_until(n + 18); pulse_done(12'h102);
    wait_until(n + 24); pulse_done(12'h105);
    wait_until(n + 30);
`else
    // basic: 3 us at 4 cycles/us; a stray done during SETTLE must be ignored
    issue_start(15'd3, n);
    q_busy.push_back(n + 1);
    q_conv.push_back(n + 13);
    q_done.push_back('{n + 16, 12'hABC, 1'b1, 1'b0});
    wait_until(n + 5);  pulse_done(12'h111);
    wait_until(n + 15); pulse_done(12'hABC);
    wait_until(n + 20);

    // zero time, then a start while busy that would restart settling if accepted
    issue_start(15'd0, n);
    q_busy.push_back(n + 1);
    q_conv.push_back(n + 1);
    q_done.push_back('{n + 4, 12'h5A5, 1'b1, 1'b0});
    wait_until(n + 2);
    time_us = 15'd3; start = 1'b1; tick(); start = 1'b0;
    pulse_done(12'h5A5);
    wait_until(n + 10);

    // timeout: 8 conv cycles without done, result keeps 0x5A5
    issue_start(15'd1, n);
    q_busy.push_back(n + 1);
    q_conv.push_back(n + 5);
    q_done.push_back('{n + 13, 12'h5A5, 1'b0, 1'b1});
    wait_until(n + 16);

    // done on the final timeout cycle wins
    issue_start(15'd0, n);
    q_busy.push_back(n + 1);
    q_conv.push_back(n + 1);
    q_done.push_back('{n + 9, 12'h3C3, 1'b1, 1'b0});
    wait_until(n + 8); pulse_done(12'h3C3);
    wait_until(n + 12);

    // time_us change mid-settle has no effect
    issue_start(15'd3, n);
    q_busy.push_back(n + 1);
    q_conv.push_back(n + 13);
    q_done.push_back('{n + 14, 12'h0F0, 1'b1, 1'b0});
    wait_until(n + 4); time_us = 15'd100;
    wait_until(n + 13); pulse_done(12'h0F0);
    wait_until(n + 18);

    // reset mid-settle clears everything at once, then a normal sequence
    issue_start(15'd2, n);
    q_busy.push_back(n + 1);
    q_done.push_back('{n + 3, 12'h000, 1'b0, 1'b0});
    wait_until(n + 3); arst = 1'b1;
    wait_until(n + 4); arst = 1'b0;
    wait_until(n + 6);
    issue_start(15'd1, n);
    q_busy.push_back(n + 1);
    q_conv.push_back(n + 5);
    q_done.push_back('{n + 7, 12'h7E7, 1'b1, 1'b0});
    wait_until(n + 6); pulse_done(12'h7E7);
    wait_until(n + 12);
`endif

    chk("pending_busy_events", q_busy.size(), 0);
    chk("pending_conv_events", q_conv.size(), 0);
    chk("pending_done_events", q_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
